// File: rtl/adder_ctrl_pkg.sv
// rtl/adder_ctrl_pkg.sv - shared state, op encoding and sizing helper for nibble-serial arithmetic
package adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of 4-bit nibbles in a WIDTH-bit operand.
    function automatic int nib_count(input int width);
        return width / 4;
    endfunction

endpackage

// File: rtl/csa_4b.sv
// rtl/csa_4b.sv - 4-bit carry-select adder shared by the nibble-serial controller
module CSA_4b (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [2:0] lo_sum;
    logic [2:0] hi_sum0;
    logic [2:0] hi_sum1;
    logic [2:0] hi_sum;

    // Low pair ripples from cin; high pair is precomputed for both carries and selected.
    always_comb begin
        lo_sum  = {1'b0, a_i[1:0]} + {1'b0, b_i[1:0]} + {2'b00, cin_i};
        hi_sum0 = {1'b0, a_i[3:2]} + {1'b0, b_i[3:2]};
        hi_sum1 = hi_sum0 + 3'd1;
        hi_sum  = lo_sum[2] ? hi_sum1 : hi_sum0;
        sum_o   = {hi_sum[1:0], lo_sum[1:0]};
        cout_o  = hi_sum[2];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit add/subtract processed one nibble per clock
module nibble_serial_adder
    import adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB = nib_count(WIDTH);
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             carry_q;
    logic [CW-1:0]    nib_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             last_nib;
    logic             ovf_d;

    // Route the nibble addressed by the counter into the shared adder.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIB; i++) begin
            if (nib_cnt_q == CW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    CSA_4b u_csa (
        .a_i    (nib_a),
        .b_i    (nib_b),
        .cin_i  (carry_q),
        .sum_o  (nib_sum),
        .cout_o (nib_cout)
    );

    // Merge this cycle's nibble result into the accumulator and derive overflow from it.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < NIB; i++) begin
            if (nib_cnt_q == CW'(i)) begin
                acc_d[4*i +: 4] = nib_sum;
            end
        end
        last_nib = (nib_cnt_q == CW'(NIB - 1));
        ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Controller FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            nib_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q       <= a;
                        b_q       <= (op_sub == OP_SUB) ? ~b : b;
                        carry_q   <= op_sub;
                        nib_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                RUN: begin
                    acc_q     <= acc_d;
                    carry_q   <= nib_cout;
                    nib_cnt_q <= nib_cnt_q + CW'(1);
                    if (last_nib) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= acc_d;
                        cout_q  <= nib_cout;
                        ovf_q   <= ovf_d;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential multi-word adder/subtractor built around one instance of the team's 4-bit carry-select adder. The block latches two WIDTH-bit operands, then adds or subtracts them one nibble per clock, LSB nibble first, with a carry register between nibbles. It is the controller that shares the single 4-bit adder datapath across the nibbles of a wide operation. Completion is signalled with a one-cycle done pulse, and the result is held until the next operation.

## Interface
- WIDTH, 16: operand width; must be a multiple of 4 and ≥ 4. NIB = WIDTH/4.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a new operation; sampled only in IDLE or DONE
- op_sub  in  1  0 = A+B, 1 = A−B; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high while nibbles are being processed (RUN)
- done  out  1  one-cycle pulse; result outputs are valid
- sum  out  WIDTH  result; held from done until the next completion
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow
- ovf  out  1  two's-complement overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch a into a_reg.
  - latch b, or ~b when op_sub=1, into b_reg.
  - set carry_reg = op_sub and nib_cnt = 0.
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN:
  - adder inputs are a_reg[4k+3:4k], b_reg[4k+3:4k] and carry_reg, where k = nib_cnt.
  - each clock, write the 4-bit sum into acc[4k+3:4k], move adder Cout into carry_reg and increment nib_cnt.
  - when nib_cnt = NIB−1, go to DONE after this edge.
  - start is ignored in RUN.
- DONE (one cycle):
  - done=1.
  - sum, cout and ovf are loaded at the entry edge from acc, the final carry and the overflow rule.
  - if start=1 in this cycle, the new operation is accepted exactly as from IDLE and the next state is RUN (back-to-back). Otherwise the next state is IDLE.
- Overflow rule: ovf = (a_reg[W−1] == b_reg[W−1]) && (acc[W−1] != a_reg[W−1]). b_reg is already inverted for subtract.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Reset, asynchronous and effective at any time including mid-RUN:
  - state = IDLE; busy = 0; done = 0; sum = 0; cout = 0; ovf = 0.
  - nib_cnt = 0; carry_reg = 0; a_reg = b_reg = acc = 0.
  - a partial operation is discarded and produces no done.

## Timing
- start is sampled at edge E0. busy=1 for exactly NIB cycles, the cycles after edges E0..E(NIB−1).
- done=1 in the single cycle after edge E(NIB). Latency from start to done is NIB+1 cycles; 5 for WIDTH=16.
- Throughput with back-to-back starts: one operation per NIB+1 cycles.
- busy and done are registered (decoded from the state register). They are never high together.
- sum, cout and ovf change only at the DONE-entry edge and at reset. They are stable otherwise, including during a following RUN.
- Adder path: nibble select → 4-bit adder → acc/carry_reg must complete in one cycle.

## Structure
- Shared package `adder_ctrl_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - op encoding constants OP_ADD=0 and OP_SUB=1.
  - NIB derivation helper.
- One sub-module: the existing 4-bit carry-select adder CSA_4b, instantiated once.
- Counter width is $clog2(NIB), minimum 1.
- WIDTH legality is checked at elaboration.

## Test plan
- Reset, then WIDTH=16, start with a=0x1234, b=0x0FCD, op_sub=0.
  - busy for cycles 1–4, done in cycle 5.
  - sum=0x2201, cout=0, ovf=0.
- a=0xFFFF, b=0x0001 add → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 add → sum=0x8000, cout=0, ovf=1.
- Subtract 0x0005−0x0007 → sum=0xFFFE, cout=0, ovf=0. Then 0x8000−0x0001 → sum=0x7FFF, cout=1, ovf=1.
- start held high continuously with changing operands.
  - operations are accepted only in IDLE or DONE, and mid-RUN operand changes have no effect.
  - done pulses every 5 cycles with the correct results; sum holds between pulses.
- Assert rst_n low in the 2nd RUN cycle of 0x1234+0x0FCD.
  - all outputs go to 0 immediately; no done follows.
  - the next operation, 0x0001+0x0001, yields 0x0002.
- WIDTH=4 instance: 0x9+0x9 → done on cycle 2, sum=0x2, cout=1, ovf=1.
